// File: rtl/calculator_dec_seq_pkg.sv
// Shared encodings, state type and width helpers for the sequential decimal calculator.
package calc_dec_pkg;

    localparam logic [2:0] FUNC_PASS = 3'b000;
    localparam logic [2:0] FUNC_ADD  = 3'b001;
    localparam logic [2:0] FUNC_SUB  = 3'b010;
    localparam logic [2:0] FUNC_MUL  = 3'b011;
    localparam logic [2:0] FUNC_DIV  = 3'b100;
    localparam logic [2:0] FUNC_MOD  = 3'b101;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        CONV,
        DONE
    } state_e;

    function automatic longint unsigned calc_max(input int unsigned digits);
        longint unsigned lim;
        lim = 1;
        for (int unsigned i = 0; i < digits; i++) lim = lim * 10;
        return lim - 1;
    endfunction

    // Bits needed to hold 10^digits - 1, i.e. ceil(log2(10^digits)).
    function automatic int unsigned calc_w(input int unsigned digits);
        longint unsigned lim;
        int unsigned     w;
        lim = calc_max(digits) + 1;
        w   = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            if ((64'd1 << i) < lim) w = i + 1;
        end
        return w;
    endfunction

    function automatic logic func_ok(input logic [2:0] f);
        return (f >= FUNC_ADD) && (f <= FUNC_MOD);
    endfunction

endpackage

// File: rtl/calculator_dec_seq_if.sv
// Keypad-side and display-side signal bundle of the sequential decimal calculator.
interface calculator_dec_seq_if #(parameter int unsigned DIGITS = 4);

    logic                  clr;
    logic                  key_valid;
    logic [3:0]            key_digit;
    logic                  func_valid;
    logic [2:0]            func;
    logic                  get_res;
    logic [4*DIGITS-1:0]   res;
    logic                  res_valid;
    logic                  err;
    logic                  busy;

    modport master (
        output clr, key_valid, key_digit, func_valid, func, get_res,
        input  res, res_valid, err, busy
    );

    modport slave (
        input  clr, key_valid, key_digit, func_valid, func, get_res,
        output res, res_valid, err, busy
    );

endinterface

// File: rtl/calculator_dec_seq_bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter: one bit per cycle, W cycles per conversion.
module bcd_conv_seq #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned W      = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [W-1:0]        din,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]        bin_q, bin_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                active_q, active_d;

    function automatic logic [4*DIGITS+W-1:0] dabble(input logic [4*DIGITS-1:0] b,
                                                     input logic [W-1:0]        x);
        logic [4*DIGITS-1:0] adj;
        adj = b;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj, x} << 1;
    endfunction

    // The load edge already performs the first shift, so the last shift lands W edges after start.
    always_comb begin
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            {bcd_d, bin_d} = dabble('0, din);
            cnt_d          = CW'(W - 1);
            active_d       = 1'b1;
        end else if (active_q && (cnt_q != '0)) begin
            {bcd_d, bin_d} = dabble(bcd_q, bin_q);
            cnt_d          = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign done = active_q && (cnt_q == '0);
    assign bcd  = bcd_q;

endmodule

// File: rtl/calculator_dec_seq.sv
// Sequential decimal keypad calculator: digit entry, binary arithmetic, BCD result conversion.
// Define CALC_DIV_EN to build the restoring divider behind div/mod.
module calculator_dec_seq
    import calc_dec_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    calculator_dec_seq_if.slave  bus
);

    localparam int unsigned W    = calc_w(DIGITS);
    localparam int unsigned DW   = 2 * W;
    localparam int unsigned CNTW = $clog2(DIGITS + 1);
    localparam logic [DW-1:0] MAX_VAL = DW'(calc_max(DIGITS));

    state_e              state_q, state_d;
    logic [W-1:0]        a_q, a_d, b_q, b_d, result_q, result_d;
    logic [CNTW-1:0]     dcnt_q, dcnt_d;
    logic [2:0]          op_q, op_d;
    logic [4*DIGITS-1:0] res_q, res_d;
    logic                res_valid_q, res_valid_d, err_q, err_d;

    logic                key_acc, func_acc, conv_start, conv_done;
    logic [4*DIGITS-1:0] conv_bcd;
    logic [DW-1:0]       exec_val;
    logic                exec_err, exec_ready;

`ifdef CALC_DIV_EN
    localparam int unsigned CW = $clog2(W + 1);
    logic [W:0]    rem_q, rem_d, rem_s;
    logic [W-1:0]  quo_q, quo_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
`endif

    function automatic logic [W-1:0] push_digit(input logic [W-1:0] v, input logic [3:0] d);
        logic [DW-1:0] t;
        t = DW'(v) * DW'(10) + DW'(d);
        return t[W-1:0];
    endfunction

    assign key_acc  = bus.key_valid && (bus.key_digit <= 4'd9);
    assign func_acc = bus.func_valid && func_ok(bus.func);

    always_comb begin
        exec_val   = '0;
        exec_err   = 1'b0;
        exec_ready = 1'b1;
        case (op_q)
            FUNC_PASS: exec_val = DW'(a_q);
            FUNC_ADD:  exec_val = DW'(a_q) + DW'(b_q);
            FUNC_SUB:  if (b_q > a_q) exec_err = 1'b1;
                       else exec_val = DW'(a_q) - DW'(b_q);
            FUNC_MUL:  exec_val = DW'(a_q) * DW'(b_q);
`ifdef CALC_DIV_EN
            FUNC_DIV, FUNC_MOD: begin
                if (b_q == '0)            exec_err   = 1'b1;
                else if (div_cnt_q != '0) exec_ready = 1'b0;
                else exec_val = (op_q == FUNC_DIV) ? DW'(quo_q) : DW'(rem_q);
            end
`endif
            default:   exec_err = 1'b1;
        endcase
        if (exec_val > MAX_VAL) exec_err = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        dcnt_d      = dcnt_q;
        op_d        = op_q;
        result_d    = result_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        err_d       = err_q;
        conv_start  = 1'b0;
`ifdef CALC_DIV_EN
        // Divider free-runs while its count is nonzero; a fresh load below overrides the step.
        rem_s     = '0;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_cnt_d = div_cnt_q;
        if (div_cnt_q != '0) begin
            rem_s = {rem_q[W-1:0], quo_q[W-1]};
            quo_d = {quo_q[W-2:0], 1'b0};
            if (rem_s >= {1'b0, b_q}) begin
                rem_d    = rem_s - {1'b0, b_q};
                quo_d[0] = 1'b1;
            end else begin
                rem_d = rem_s;
            end
            div_cnt_d = div_cnt_q - CW'(1);
        end
`endif
        if (bus.clr) begin
            state_d     = ENTER_A;
            a_d         = '0;
            b_d         = '0;
            dcnt_d      = '0;
            op_d        = FUNC_PASS;
            result_d    = '0;
            res_d       = '0;
            res_valid_d = 1'b0;
            err_d       = 1'b0;
`ifdef CALC_DIV_EN
            rem_d     = '0;
            quo_d     = '0;
            div_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                ENTER_A, ENTER_B: begin
                    if (bus.get_res) begin
                        state_d = EXEC;
                        if (state_q == ENTER_A) op_d = FUNC_PASS;
`ifdef CALC_DIV_EN
                        else if ((op_q == FUNC_DIV) || (op_q == FUNC_MOD)) begin
                            rem_d     = '0;
                            quo_d     = a_q;
                            div_cnt_d = CW'(W);
                        end
`endif
                    end else if (func_acc) begin
                        op_d = bus.func;
                        if (state_q == ENTER_A) begin
                            b_d     = '0;
                            dcnt_d  = '0;
                            state_d = ENTER_B;
                        end
                    end else if (key_acc && (dcnt_q < CNTW'(DIGITS))) begin
                        if (state_q == ENTER_A) a_d = push_digit(a_q, bus.key_digit);
                        else                    b_d = push_digit(b_q, bus.key_digit);
                        dcnt_d = dcnt_q + CNTW'(1);
                    end
                end
                EXEC: begin
                    if (exec_ready) begin
                        if (exec_err) begin
                            state_d     = DONE;
                            res_d       = '0;
                            err_d       = 1'b1;
                            res_valid_d = 1'b1;
                        end else begin
                            result_d   = exec_val[W-1:0];
                            conv_start = 1'b1;
                            state_d    = CONV;
                        end
                    end
                end
                CONV: begin
                    if (conv_done) begin
                        state_d     = DONE;
                        res_d       = conv_bcd;
                        err_d       = 1'b0;
                        res_valid_d = 1'b1;
                    end
                end
                DONE: begin
                    if (bus.get_res) begin
                        state_d = DONE;
                    end else if (func_acc) begin
                        if (!err_q) begin
                            a_d         = result_q;
                            b_d         = '0;
                            dcnt_d      = '0;
                            op_d        = bus.func;
                            result_d    = '0;
                            res_d       = '0;
                            res_valid_d = 1'b0;
                            state_d     = ENTER_B;
                        end
                    end else if (key_acc) begin
                        a_d         = W'(bus.key_digit);
                        b_d         = '0;
                        dcnt_d      = CNTW'(1);
                        op_d        = FUNC_PASS;
                        result_d    = '0;
                        res_d       = '0;
                        res_valid_d = 1'b0;
                        err_d       = 1'b0;
                        state_d     = ENTER_A;
                    end
                end
                default: state_d = ENTER_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ENTER_A;
            a_q         <= '0;
            b_q         <= '0;
            dcnt_q      <= '0;
            op_q        <= FUNC_PASS;
            result_q    <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            dcnt_q      <= dcnt_d;
            op_q        <= op_d;
            result_q    <= result_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

`ifdef CALC_DIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            div_cnt_q <= '0;
        end else begin
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_cnt_q <= div_cnt_d;
        end
    end
`endif

    bcd_conv_seq #(.DIGITS(DIGITS), .W(W)) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .din   (exec_val[W-1:0]),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign bus.res       = res_q;
    assign bus.res_valid = res_valid_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q == EXEC) || (state_q == CONV);

endmodule

// File: tb/tb_calculator_dec_seq.sv
// Bench for calculator_dec_seq: directed and random key sequences, results checked by a
// scoreboard fed from a decimal reference model.
`timescale 1ns/1ps
module tb_calculator_dec_seq;

    localparam int unsigned DIGITS = 4;
    localparam int LAT_CONV = 15;
    localparam int LAT_DIV  = 29;
    localparam longint MAXV = 9999;

    typedef struct {
        logic [15:0] res;
        logic        err;
        int          lat;
        int          issue;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic rv_prev = 1'b0;

    // reference model: st 0 = entering A, 1 = entering B, 2 = result shown
    longint m_a = 0, m_b = 0, m_res = 0;
    int     m_op = 0, m_cnt = 0, m_st = 0;
    bit     m_err = 0;

    calculator_dec_seq_if #(.DIGITS(DIGITS)) bus();

    calculator_dec_seq #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.res_valid && !rv_prev) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: res=0x%0h err=%0b with nothing expected", bus.res, bus.err);
            end else begin
                mon_e = sb.pop_front();
                check("res", 64'(bus.res), 64'(mon_e.res));
                check("err", 64'(bus.err), 64'(mon_e.err));
                check("latency", 64'(cyc - mon_e.issue), 64'(mon_e.lat));
            end
        end
        rv_prev = bus.res_valid;
    end

    function automatic logic [15:0] to_bcd(input longint v);
        logic [15:0] r;
        longint      x;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic void model_key(input int d);
        if (d > 9) return;
        if (m_st == 2) begin
            m_a = d; m_b = 0; m_cnt = 1; m_st = 0; m_err = 0;
        end else if (m_cnt < 4) begin
            if (m_st == 0) m_a = m_a * 10 + d;
            else           m_b = m_b * 10 + d;
            m_cnt++;
        end
    endfunction

    function automatic void model_func(input int f);
        if (f < 1 || f > 5) return;
        if (m_st == 0) begin
            m_op = f; m_b = 0; m_cnt = 0; m_st = 1;
        end else if (m_st == 1) begin
            m_op = f;
        end else if (!m_err) begin
            m_a = m_res; m_op = f; m_b = 0; m_cnt = 0; m_st = 1;
        end
    endfunction

    function automatic void model_clr();
        m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_cnt = 0; m_st = 0; m_err = 0;
    endfunction

    function automatic void model_get(input int issue);
        longint v;
        bit     e;
        int     op;
        exp_t   x;
        v  = 0;
        e  = 0;
        op = (m_st == 0) ? 0 : m_op;
        case (op)
            1: v = m_a + m_b;
            2: if (m_b > m_a) e = 1; else v = m_a - m_b;
            3: v = m_a * m_b;
`ifdef CALC_DIV_EN
            4: if (m_b == 0) e = 1; else v = m_a / m_b;
            5: if (m_b == 0) e = 1; else v = m_a % m_b;
`else
            4, 5: e = 1;
`endif
            default: v = m_a;
        endcase
        if (!e && v > MAXV) e = 1;
        x.res   = e ? 16'h0000 : to_bcd(v);
        x.err   = e;
        x.lat   = e ? 1 : ((op == 4 || op == 5) ? LAT_DIV : LAT_CONV);
        x.issue = issue;
        sb.push_back(x);
        m_res = e ? 0 : v;
        m_err = e;
        m_st  = 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int d);
        bit was_done;
        was_done = (m_st == 2) && (d <= 9);
        bus.key_valid = 1'b1;
        bus.key_digit = 4'(d);
        tick();
        bus.key_valid = 1'b0;
        model_key(d);
        if (was_done) check("rv_fall_key", 64'(bus.res_valid), 64'd0);
    endtask

    task automatic keys(input string s);
        for (int i = 0; i < s.len(); i++) press(int'(s[i]) - 48);
    endtask

    task automatic func_press(input int f);
        bit leaves;
        leaves = (m_st == 2) && !m_err && (f >= 1) && (f <= 5);
        bus.func_valid = 1'b1;
        bus.func       = 3'(f);
        tick();
        bus.func_valid = 1'b0;
        model_func(f);
        if (leaves)         check("rv_fall_func", 64'(bus.res_valid), 64'd0);
        else if (m_st == 2) check("rv_hold_func", 64'(bus.res_valid), 64'd1);
    endtask

    task automatic get_nowait();
        bus.get_res = 1'b1;
        tick();
        bus.get_res = 1'b0;
        model_get(cyc);
        check("busy_after_get", 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!bus.res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.res_valid) check("result_timeout", 64'(bus.res_valid), 64'd1);
        tick();
    endtask

    task automatic get_press();
        if (m_st != 2) begin
            get_nowait();
            wait_result();
        end else begin
            bus.get_res = 1'b1;
            tick();
            bus.get_res = 1'b0;
        end
    endtask

    task automatic clr_press();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        model_clr();
        sb.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_rv"},   64'(bus.res_valid), 64'd0);
        check({tag, "_err"},  64'(bus.err), 64'd0);
        check({tag, "_res"},  64'(bus.res), 64'd0);
    endtask

    task automatic rand_operand();
        int n;
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 11) == 0) press($urandom_range(10, 15));
            else if ($urandom_range(0, 2) == 0) press(9);
            else press($urandom_range(0, 9));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.clr = 1'b0; bus.key_valid = 1'b0; bus.key_digit = '0;
        bus.func_valid = 1'b0; bus.func = '0; bus.get_res = 1'b0;
        #2;
        check_idle("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        keys("13"); func_press(1); keys("01"); get_press();
        check("tp_add_res", 64'(bus.res), 64'h0014);

        keys("3"); func_press(2); keys("5"); get_press();
        check("tp_sub_err", 64'(bus.err), 64'd1);
        func_press(1);
        check("tp_err_hold", 64'(bus.err), 64'd1);

        keys("9999"); func_press(1); keys("1"); get_press();
        check("tp_ovf_err", 64'(bus.err), 64'd1);

        keys("100"); func_press(4); keys("7"); get_press();
`ifdef CALC_DIV_EN
        check("tp_div_res", 64'(bus.res), 64'h0014);
`else
        check("tp_div_off_err", 64'(bus.err), 64'd1);
`endif
        keys("100"); func_press(5); keys("7"); get_press();
`ifdef CALC_DIV_EN
        check("tp_mod_res", 64'(bus.res), 64'h0002);
`else
        check("tp_mod_off_err", 64'(bus.err), 64'd1);
`endif

        keys("12345"); get_press();
        check("tp_pass_res", 64'(bus.res), 64'h1234);
        func_press(3); keys("2"); get_press();
        check("tp_chain_res", 64'(bus.res), 64'h2468);

        keys("5"); func_press(4); keys("0"); get_press();
        check("tp_div0_err", 64'(bus.err), 64'd1);

        keys("12"); func_press(1); keys("34"); get_nowait();
        repeat (5) tick();
        check("mid_conv_busy", 64'(bus.busy), 64'd1);
        clr_press();
        check_idle("after_clr");
        repeat (20) tick();
        keys("7"); get_press();
        check("after_clr_res", 64'(bus.res), 64'h0007);

        keys("9"); func_press(3); keys("9"); get_nowait();
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        model_clr();
        sb.delete();
        tick();
        keys("42"); get_press();
        check("after_rst_res", 64'(bus.res), 64'h0042);

        for (int t = 0; t < 40; t++) begin
            if (m_st == 2 && !m_err && $urandom_range(0, 2) == 0) begin
                func_press($urandom_range(1, 5));
                rand_operand();
                get_press();
            end else begin
                rand_operand();
                if ($urandom_range(0, 9) != 0) begin
                    func_press($urandom_range(1, 5));
                    rand_operand();
                end
                get_press();
            end
        end

        repeat (3) tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
